register_scoreboard: RTL

- Issue-side hazard controller for the register unit in the pipelined core.
- Tracks in-flight writes to each architectural register and stalls issue of any instruction whose sources are still pending (RAW protection).
- Releases registers as results are written back to the register unit.
- Sits between decode/issue and the register unit; the issue stage reads xs1/xs2 only after issue_ready is high.

---
 rtl/register_scoreboard.sv | 108 ++++++++++
 1 files changed

// File: rtl/register_scoreboard.sv
// register_scoreboard
// Issue-side RAW hazard controller for the register unit. Keeps a small
// pending-write counter per architectural register. Issue is stalled while
// any used source still has an outstanding write, or while the destination
// already has max_inflight writes outstanding. Writebacks release entries.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   flush                         synchronous clear of all pending counters
//   issue_valid / issue_ready     issue handshake (ready is combinational)
//   issue_uses_rs1/rs1, uses_rs2/rs2, has_rd/rd   instruction operands
//   wb_valid, wb_rd               writeback to the register unit
//   busy                          some register has a pending write
//   wb_error                      sticky: writeback to a non-pending register
//                                 or counter overflow attempt (reset clears)
//
// Optional feature, macro SCOREBOARD_BYPASS_EN: a source whose counter is 1
// and which is being written back this cycle is treated as ready (datapath
// forwards the result). Adds a wb_valid/wb_rd -> issue_ready path.

module register_scoreboard #(
    parameter int size         = 32,
    parameter int max_inflight = 3,
    localparam int AW = $clog2(size),
    localparam int CW = $clog2(max_inflight + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic          issue_uses_rs1,
    input  logic [AW-1:0] issue_rs1,
    input  logic          issue_uses_rs2,
    input  logic [AW-1:0] issue_rs2,
    input  logic          issue_has_rd,
    input  logic [AW-1:0] issue_rd,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    output logic          busy,
    output logic          wb_error
);

    localparam logic [CW-1:0] CNT_MAX = CW'(max_inflight);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt [size];
    logic          rs1_pend;
    logic          rs2_pend;
    logic          rd_full;
    logic          fire;
    logic [size-1:0] inc_vec;
    logic [size-1:0] dec_vec;

    always_comb begin
        rs1_pend = issue_uses_rs1 && (cnt[issue_rs1] != '0);
        rs2_pend = issue_uses_rs2 && (cnt[issue_rs2] != '0);
`ifdef SCOREBOARD_BYPASS_EN
        // Last outstanding write completes this cycle; operand is forwarded.
        if (wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == CNT_ONE))
            rs1_pend = 1'b0;
        if (wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == CNT_ONE))
            rs2_pend = 1'b0;
`endif
        rd_full     = issue_has_rd && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
        issue_ready = !(rs1_pend || rs2_pend || rd_full);
        fire        = issue_valid && issue_ready;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy    = 1'b0;
        // Entry 0 is x0: never incremented or decremented.
        for (int i = 1; i < size; i++) begin
            inc_vec[i] = fire && issue_has_rd && (issue_rd == AW'(i));
            dec_vec[i] = wb_valid && (wb_rd == AW'(i));
            busy       = busy || (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < size; i++)
                cnt[i] <= '0;
            wb_error <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < size; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 1; i < size; i++) begin
                // A matching increment and decrement cancel out.
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (cnt[i] == CNT_MAX)
                        wb_error <= 1'b1;
                    else
                        cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (cnt[i] == '0)
                        wb_error <= 1'b1;
                    else
                        cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

endmodule
